// File: rtl/xpb_accum_if.sv
// xpb_accum_if: term input stream and resolved-sum output stream of the xpb accumulator
interface xpb_accum_if #(
  parameter int DATA_W  = 1024,
  parameter int GUARD_W = 6
);
  localparam int OUT_W = DATA_W + GUARD_W;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_term;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_sum;
  logic              out_ovf;
  modport master (
    output in_valid, in_term, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
  modport slave (
    input  in_valid, in_term, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/xpb_accum.sv
// xpb_accum: carry-save accumulation of xpb terms, resolved by a segmented carry-propagate adder
// one segment per cycle, then held on a valid/ready output until taken.
module xpb_accum #(
  parameter int DATA_W  = 1024,
  parameter int GUARD_W = 6,
  parameter int SEG_W   = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  xpb_accum_if.slave  bus
);
  localparam int OUT_W  = DATA_W + GUARD_W;
  localparam int NSEG   = (OUT_W + SEG_W - 1) / SEG_W;
  localparam int SEG_CW = NSEG > 1 ? $clog2(NSEG) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
  state_t            state, state_nxt;
  logic [OUT_W-1:0]  s, c, t, sum_nxt;
  logic [GUARD_W:0]  term_cnt;
  logic [SEG_CW-1:0] seg;
  logic [NSEG-1:0]   co;
  logic              cin, acc, seg_end;
  assign t             = OUT_W'(bus.in_term);
  assign bus.in_ready  = state == IDLE || state == ACCUM;
  assign bus.out_valid = state == DONE;
  assign acc           = bus.in_valid & bus.in_ready;
  assign seg_end       = seg == SEG_CW'(NSEG - 1);
  // Only the active segment is rewritten; the top segment covers the leftover guard bits.
  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    localparam int LO = i * SEG_W;
    localparam int W  = (i == NSEG - 1) ? OUT_W - LO : SEG_W;
    logic [W:0] r;
    assign r               = {1'b0, s[LO+:W]} + {1'b0, c[LO+:W]} + {{W{1'b0}}, cin};
    assign sum_nxt[LO+:W]  = seg == SEG_CW'(i) ? r[W-1:0] : bus.out_sum[LO+:W];
    assign co[i]           = r[W];
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: state_nxt = acc ? (bus.in_last ? RESOLVE : ACCUM) : state;
      RESOLVE:     state_nxt = seg_end ? DONE : RESOLVE;
      DONE:        state_nxt = bus.out_ready ? IDLE : DONE;
      default:     state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s           <= '0;
      c           <= '0;
      term_cnt    <= '0;
      seg         <= '0;
      cin         <= 1'b0;
      bus.out_sum <= '0;
      bus.out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          s           <= t;
          c           <= '0;
          term_cnt    <= (GUARD_W+1)'(1);
          bus.out_ovf <= 1'b0;
        end
        ACCUM: if (acc) begin
          s <= s ^ c ^ t;
          c <= ((s & c) | (s & t) | (c & t)) << 1;
          // term_cnt saturates at 2^GUARD_W, so its top bit means the job is already full
          if (term_cnt[GUARD_W]) bus.out_ovf <= 1'b1;
          else term_cnt <= term_cnt + 1'b1;
        end
        RESOLVE: begin
          bus.out_sum <= sum_nxt;
          seg         <= seg_end ? '0 : seg + 1'b1;
          cin         <= !seg_end && co[seg];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xpb_accum.sv
// tb_xpb_accum: directed table of jobs plus back-pressure, reset-abort and gapped-input sequences
module tb_xpb_accum;
  localparam int DW = 1024;
  localparam int GW = 6;
  localparam int SW = 128;
  localparam int OW = DW + GW;
  localparam int NS = 9;
  typedef struct {
    logic [DW-1:0] term;
    int            n;
    logic [OW-1:0] sum;
    logic          ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vt[5];
  xpb_accum_if #(.DATA_W(DW), .GUARD_W(GW)) bus ();
  xpb_accum #(.DATA_W(DW), .GUARD_W(GW), .SEG_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h_..._%h exp=%h_..._%h", name, act[OW-1 -: 64], act[63:0],
               exp[OW-1 -: 64], exp[63:0]);
    end
  endtask
  task automatic send_term(input logic [DW-1:0] t, input logic last);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_term  = t;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout in_ready=0 after %0d cycles", w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk({name, "_latency"}, OW'(lat), OW'(NS));
  endtask
  task automatic take_out(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({name, "_valid_after"}, OW'(bus.out_valid), '0);
    chk({name, "_ready_after"}, OW'(bus.in_ready), OW'(1));
  endtask
  initial begin
    logic [DW-1:0] ones;
    ones = '1;
    vt[0] = '{term: DW'(1), n: 1,  sum: OW'(1),                   ovf: 1'b0};
    vt[1] = '{term: ones,   n: 2,  sum: (OW'(1) << 1025) - OW'(2), ovf: 1'b0};
    vt[2] = '{term: ones,   n: 64, sum: OW'(0) - OW'(64),          ovf: 1'b0};
    vt[3] = '{term: ones,   n: 65, sum: (OW'(1) << 1024) - OW'(65), ovf: 1'b1};
    vt[4] = '{term: DW'(5), n: 3,  sum: OW'(15),                  ovf: 1'b0};
    bus.in_valid  = 1'b0;
    bus.in_term   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", OW'(bus.out_valid), '0);
    chk("rst_in_ready", OW'(bus.in_ready), OW'(1));
    chk("rst_out_sum", bus.out_sum, '0);
    chk("rst_out_ovf", OW'(bus.out_ovf), '0);
    for (int j = 0; j < 5; j++) begin
      string nm;
      nm = $sformatf("job%0d", j);
      for (int k = 0; k < vt[j].n; k++) send_term(vt[j].term, k == vt[j].n - 1);
      wait_done(nm);
      chk({nm, "_sum"}, bus.out_sum, vt[j].sum);
      chk({nm, "_ovf"}, OW'(bus.out_ovf), OW'(vt[j].ovf));
      take_out(nm);
    end
    // back-pressure: output held, input ignored while DONE
    send_term(DW'(7), 1'b0);
    send_term(DW'(9), 1'b1);
    wait_done("bp");
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      bus.in_term  = DW'(8'hff);
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid%0d", k), OW'(bus.out_valid), OW'(1));
      chk($sformatf("bp_sum%0d", k), bus.out_sum, OW'(16));
      chk($sformatf("bp_ready%0d", k), OW'(bus.in_ready), '0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take_out("bp");
    repeat (12) @(posedge clk);
    #1;
    chk("bp_single_transfer", OW'(bus.out_valid), '0);
    // reset mid-RESOLVE discards the job
    send_term(DW'(16'h1234), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_valid", OW'(bus.out_valid), '0);
    chk("abort_ready", OW'(bus.in_ready), OW'(1));
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", OW'(bus.out_valid), '0);
    send_term(DW'(3), 1'b0);
    send_term(DW'(5), 1'b1);
    wait_done("after_abort");
    chk("after_abort_sum", bus.out_sum, OW'(8));
    take_out("after_abort");
    // gapped input
    send_term(DW'(8'h10), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_term(DW'(8'h20), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_term(DW'(8'h30), 1'b1);
    wait_done("gap");
    chk("gap_sum", bus.out_sum, OW'(8'h60));
    chk("gap_ovf", OW'(bus.out_ovf), '0);
    take_out("gap");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xpb_accum.md
Name: xpb_accum

Overview:
- Downstream consumer of the 5-bit-indexed xpb reduction lookup tables in the modular squaring datapath.
- Accepts a stream of 1024-bit xpb terms, one per cycle, and accumulates them in carry-save form.
- After the last term, resolves the sum with a segmented carry-propagate adder over several cycles.
- Presents the full-width reduced-partial sum with a valid/ready handshake to the next stage.

Parameters:
- DATA_W, 1024, width of each incoming xpb term.
- GUARD_W, 6, growth bits; one job may hold up to 2^GUARD_W terms without overflow.
- SEG_W, 128, width of each carry-propagate segment resolved per cycle.
- OUT_W, DATA_W+GUARD_W (derived), accumulator and result width.
- NSEG, ceil(OUT_W/SEG_W) (derived, 9 at defaults); the top segment may be narrower.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_term is valid.
- in_ready  out  1  block can accept a term this cycle.
- in_term  in  DATA_W  xpb term, treated as unsigned.
- in_last  in  1  marks the final term of the current job; sampled with in_valid.
- out_valid  out  1  out_sum is valid.
- out_ready  in  1  downstream accepts out_sum.
- out_sum  out  OUT_W  resolved sum, taken modulo 2^OUT_W.
- out_ovf  out  1  more than 2^GUARD_W terms were accepted in this job.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; sum/carry vectors, segment counter, term counter, out_sum, out_ovf and out_valid all cleared to 0.
  - Reset takes priority over every other event, including mid-ACCUM and mid-RESOLVE; any partial job is discarded.
- Accept rule: a term is accepted on an edge where in_valid & in_ready. In all other cycles in_term and in_last are ignored.
- in_ready is a registered function of state: 1 in IDLE and ACCUM, 0 in RESOLVE and DONE.
- States:
  - IDLE: on accept, S<=zero-extended in_term, C<=0, term_cnt<=1, out_ovf<=0. Next state is RESOLVE if in_last, else ACCUM.
  - ACCUM: on accept, 3:2 compress:
    - S<=S^C^T.
    - C<=((S&C)|(S&T)|(C&T))<<1, truncated to OUT_W.
    - T is in_term zero-extended to OUT_W.
    - term_cnt increments. When an accepted term would make term_cnt exceed 2^GUARD_W, set out_ovf (sticky for the job); term_cnt saturates.
    - On accept with in_last, next state is RESOLVE.
    - No accept means state holds.
  - RESOLVE: NSEG cycles; segment counter seg=0..NSEG-1.
    - Each cycle: out_sum[seg] <= S[seg]+C[seg]+cin, then cin <= carry-out. cin=0 at seg 0.
    - The final carry-out is dropped.
    - After seg NSEG-1, next state is DONE.
  - DONE: out_valid=1; out_sum and out_ovf held stable while out_ready=0. On out_valid & out_ready, out_valid<=0 and next state is IDLE.
- out_valid is 0 in every state except DONE.
- Latency: last term accepted at edge k ⇒ RESOLVE occupies edges k+1..k+NSEG ⇒ out_valid=1 after edge k+NSEG. That is 9 cycles at defaults.
- Throughput: one job per (terms + NSEG + 1) cycles minimum. There is no overlap between resolving one job and accepting the next.
- Single-term job: the IDLE accept with in_last goes directly to RESOLVE, and out_sum equals that term.
- Exactly 2^GUARD_W terms of all-ones fit without wrap. Beyond that the sum wraps modulo 2^OUT_W and out_ovf=1.
- out_ready asserted outside DONE has no effect.
- Simultaneous out_ready in DONE and in_valid: the term is not accepted that cycle (in_ready=0). It is accepted in the following IDLE cycle if still presented.

Test Plan:
- Reset, then one term 0x1 with in_last → after 9 cycles out_valid=1, out_sum=1, out_ovf=0; handshake with out_ready=1 returns to IDLE with in_ready=1.
- Two terms of 2^1024-1, second with in_last → out_sum=2^1025-2, out_ovf=0; carries propagate across all 9 segments.
- 64 terms of 2^1024-1 → out_sum=2^1030-64, out_ovf=0. Repeat with 65 terms → out_sum=(65·(2^1024-1)) mod 2^1030, out_ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, out_sum unchanged, in_ready=0, and in_valid pulses are ignored; release → one transfer only.
- Drop rst_n for one edge during RESOLVE → next cycle out_valid=0 and in_ready=1. A following job of terms 3 and 5 yields out_sum=8.
- Gapped input: terms 0x10, 0x20, 0x30 with in_valid low for 2 cycles between each → out_sum=0x60; latency measured from the in_last accept equals NSEG.
